// File: rtl/cas_tape_player.sv
// cas_tape_player: captures a CAS image from the HPS ioctl download path into
// a byte buffer, then replays it to the cassette input as a frequency-encoded
// bit stream while the core's motor line is on.
module cas_tape_player #(
  parameter int ADDR_W      = 16,
  parameter int CAS_INDEX   = 2,
  parameter int HDR_SKIP    = 16,
  parameter int LEADER_BITS = 256,
  parameter int HALF0       = 4464,
  parameter int HALF1       = 2232,
  parameter int FAST_SHIFT  = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic        ioctl_download_i,
  input  logic [7:0]  ioctl_index_i,
  input  logic        ioctl_wr_i,
  input  logic [24:0] ioctl_addr_i,
  input  logic [7:0]  ioctl_dout_i,
  input  logic        motor_i,
  input  logic        fast_i,
  input  logic        sound_en_i,
  output logic        tape_o,
  output logic [10:0] audio_o,
  output logic        busy_o,
  output logic        end_o,
  output logic        overflow_o
);

  localparam int HMAX  = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int CNT_W = $clog2(HMAX + 1);
  localparam int LDR_W = $clog2(LEADER_BITS + 1);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE, LEADER, FETCH, START, DATA, STOP, DONE
  } state_t;

  // Half-period length for a cell; fast_n=0 selects the shortened timing.
  function automatic logic [CNT_W-1:0] half_len(input logic b, input logic fast_n);
    int h;
    h = b ? HALF1 : HALF0;
    if (!fast_n) h = h >> FAST_SHIFT;
    return CNT_W'(h);
  endfunction

  state_t             state_q, state_d;
  logic [ADDR_W:0]    ptr_q, ptr_d;
  logic [ADDR_W:0]    length_q, length_d;
  logic               loaded_q, loaded_d;
  logic               load_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hlen_q, hlen_d;
  logic               half_q, half_d;
  logic [LDR_W-1:0]   ldr_q, ldr_d;
  logic [2:0]         bit_q, bit_d;
  logic               tape_q, tape_d;
  logic               end_q, end_d;
  logic               ovf_q, ovf_d;

  logic [7:0]         mem [DEPTH];
  logic [7:0]         rd_data;

  logic               load;
  logic               in_range;
  logic [ADDR_W:0]    wr_len;
  logic [ADDR_W:0]    ptr_inc;
  logic [CNT_W-1:0]   cnt_inc;
  logic               cell_done;
  logic               start_cell;
  logic               start_bit;

  assign load     = ioctl_download_i && (ioctl_index_i == 8'(CAS_INDEX));
  assign in_range = (ioctl_addr_i >> ADDR_W) == 25'd0;
  assign wr_len   = {1'b0, ioctl_addr_i[ADDR_W-1:0]} + {{ADDR_W{1'b0}}, 1'b1};
  assign ptr_inc  = ptr_q + {{ADDR_W{1'b0}}, 1'b1};
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Buffer write port, fed only by the tape download.
  always_ff @(posedge clk_i) begin
    if (load && ioctl_wr_i && in_range)
      mem[ioctl_addr_i[ADDR_W-1:0]] <= ioctl_dout_i;
  end

  // Registered buffer read, issued for one clock in FETCH.
  always_ff @(posedge clk_i) begin
    if (state_q == FETCH)
      rd_data <= mem[ptr_q[ADDR_W-1:0]];
  end

  // Next-state, cell timing and download bookkeeping.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    length_d   = length_q;
    loaded_d   = loaded_q;
    cnt_d      = cnt_q;
    hlen_d     = hlen_q;
    half_d     = half_q;
    ldr_d      = ldr_q;
    bit_d      = bit_q;
    tape_d     = tape_q;
    end_d      = end_q;
    ovf_d      = ovf_q;
    cell_done  = 1'b0;
    start_cell = 1'b0;
    start_bit  = 1'b0;

    // Shared half-period timer; motor off simply withholds the tick.
    if ((state_q inside {LEADER, START, DATA, STOP}) && ce_i && motor_i) begin
      if (cnt_inc == hlen_q) begin
        cnt_d = '0;
        if (!half_q) begin
          half_d = 1'b1;
          tape_d = 1'b0;
        end else begin
          cell_done = 1'b1;
        end
      end else begin
        cnt_d = cnt_inc;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (loaded_q && motor_i && !load) begin
          ptr_d      = (ADDR_W+1)'(HDR_SKIP);
          ldr_d      = '0;
          state_d    = LEADER;
          start_cell = 1'b1;
          start_bit  = 1'b1;
        end
      end
      LEADER: begin
        if (cell_done) begin
          if (ldr_q == LDR_W'(LEADER_BITS - 1)) begin
            state_d = FETCH;
          end else begin
            ldr_d      = ldr_q + LDR_W'(1);
            start_cell = 1'b1;
            start_bit  = 1'b1;
          end
        end
      end
      FETCH: begin
        // Start bit is always 0, so it can begin while the read lands.
        state_d    = START;
        start_cell = 1'b1;
        start_bit  = 1'b0;
      end
      START: begin
        if (cell_done) begin
          state_d    = DATA;
          bit_d      = 3'd0;
          start_cell = 1'b1;
          start_bit  = rd_data[0];
        end
      end
      DATA: begin
        if (cell_done) begin
          start_cell = 1'b1;
          if (bit_q == 3'd7) begin
            state_d   = STOP;
            bit_d     = 3'd0;
            start_bit = 1'b1;
          end else begin
            bit_d     = bit_q + 3'd1;
            start_bit = rd_data[bit_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (cell_done) begin
          if (bit_q == 3'd0) begin
            bit_d      = 3'd1;
            start_cell = 1'b1;
            start_bit  = 1'b1;
          end else begin
            ptr_d = ptr_inc;
            if (ptr_inc == length_q) begin
              state_d = DONE;
              end_d   = 1'b1;
            end else begin
              state_d = FETCH;
            end
          end
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    // Every cell opens with its high half; fast_i is latched here only.
    if (start_cell) begin
      tape_d = 1'b1;
      half_d = 1'b0;
      cnt_d  = '0;
      hlen_d = half_len(start_bit, fast_i);
    end

    // A new tape download overrides whatever playback was doing.
    if (load && !load_q) begin
      state_d  = IDLE;
      length_d = '0;
      loaded_d = 1'b0;
      ovf_d    = 1'b0;
      end_d    = 1'b0;
      tape_d   = 1'b0;
      half_d   = 1'b0;
      cnt_d    = '0;
    end

    if (load && ioctl_wr_i) begin
      if (in_range) begin
        if (wr_len > length_d) length_d = wr_len;
      end else begin
        ovf_d = 1'b1;
      end
    end

    // An image holding nothing past the header never arms playback.
    if (!load && load_q)
      loaded_d = (int'(length_q) > HDR_SKIP);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      length_q <= '0;
      loaded_q <= 1'b0;
      load_q   <= 1'b0;
      cnt_q    <= '0;
      hlen_q   <= '0;
      half_q   <= 1'b0;
      ldr_q    <= '0;
      bit_q    <= 3'd0;
      tape_q   <= 1'b0;
      end_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      length_q <= length_d;
      loaded_q <= loaded_d;
      load_q   <= load;
      cnt_q    <= cnt_d;
      hlen_q   <= hlen_d;
      half_q   <= half_d;
      ldr_q    <= ldr_d;
      bit_q    <= bit_d;
      tape_q   <= tape_d;
      end_q    <= end_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tape_o     = tape_q;
  assign audio_o    = (tape_q && sound_en_i) ? 11'h200 : 11'h000;
  assign busy_o     = (state_q != IDLE) && (state_q != DONE);
  assign end_o      = end_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_cas_tape_player.sv
// tb_cas_tape_player: randomized scenarios checked against a cell-level model
// of the tape stream built from the downloaded image.
module tb_cas_tape_player;

  localparam int ADDR_W      = 5;
  localparam int CAS_INDEX   = 2;
  localparam int HDR_SKIP    = 16;
  localparam int LEADER_BITS = 8;
  localparam int HALF0       = 48;
  localparam int HALF1       = 24;
  localparam int FAST_SHIFT  = 3;
  localparam int CAP         = 1 << ADDR_W;
  localparam int LIM         = 30000;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ce_i;
  logic        ioctl_download_i;
  logic [7:0]  ioctl_index_i;
  logic        ioctl_wr_i;
  logic [24:0] ioctl_addr_i;
  logic [7:0]  ioctl_dout_i;
  logic        motor_i;
  logic        fast_i;
  logic        sound_en_i;
  logic        tape_o;
  logic [10:0] audio_o;
  logic        busy_o;
  logic        end_o;
  logic        overflow_o;

  int errors = 0;
  int checks = 0;
  int ce_div = 2;
  int ce_ph  = 0;
  int cur_idx = 0;

  byte unsigned model_mem [CAP];
  int           model_len = 0;
  byte unsigned img [64];

  cas_tape_player #(
    .ADDR_W(ADDR_W), .CAS_INDEX(CAS_INDEX), .HDR_SKIP(HDR_SKIP),
    .LEADER_BITS(LEADER_BITS), .HALF0(HALF0), .HALF1(HALF1), .FAST_SHIFT(FAST_SHIFT)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .ce_i(ce_i),
    .ioctl_download_i(ioctl_download_i), .ioctl_index_i(ioctl_index_i),
    .ioctl_wr_i(ioctl_wr_i), .ioctl_addr_i(ioctl_addr_i), .ioctl_dout_i(ioctl_dout_i),
    .motor_i(motor_i), .fast_i(fast_i), .sound_en_i(sound_en_i),
    .tape_o(tape_o), .audio_o(audio_o), .busy_o(busy_o), .end_o(end_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // ce strobe: one clock in every ce_div
  initial begin
    ce_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      ce_ph = (ce_ph + 1 >= ce_div) ? 0 : ce_ph + 1;
      ce_i  = (ce_ph == 0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic dl_begin(input int idx);
    step(1);
    cur_idx = idx;
    ioctl_index_i = 8'(idx);
    ioctl_download_i = 1'b1;
    if (idx == CAS_INDEX) model_len = 0;
  endtask

  task automatic dl_byte(input int addr, input byte unsigned data);
    step(1);
    ioctl_addr_i = 25'(addr);
    ioctl_dout_i = data;
    ioctl_wr_i   = 1'b1;
    step(1);
    ioctl_wr_i   = 1'b0;
    if (cur_idx == CAS_INDEX && addr < CAP) begin
      model_mem[addr] = data;
      if (addr + 1 > model_len) model_len = addr + 1;
    end
  endtask

  task automatic dl_end();
    step(1);
    ioctl_download_i = 1'b0;
    step(2);
  endtask

  task automatic download(input int idx, input int n);
    dl_begin(idx);
    for (int a = 0; a < n; a++) dl_byte(a, img[a]);
    dl_end();
  endtask

  task automatic rand_img(input int n);
    for (int a = 0; a < n; a++) img[a] = 8'($urandom);
  endtask

  // Builds the expected half-period list and follows the stream cell by cell.
  task automatic play_check(input string name);
    int exp_h[$];
    int sh, hi, lo, g;
    sh = fast_i ? 0 : FAST_SHIFT;
    for (int i = 0; i < LEADER_BITS; i++) exp_h.push_back(HALF1 >> sh);
    for (int p = HDR_SKIP; p < model_len; p++) begin
      exp_h.push_back(HALF0 >> sh);
      for (int b = 0; b < 8; b++)
        exp_h.push_back(model_mem[p][b] ? (HALF1 >> sh) : (HALF0 >> sh));
      exp_h.push_back(HALF1 >> sh);
      exp_h.push_back(HALF1 >> sh);
    end
    g = 0;
    @(negedge clk_i);
    while (tape_o !== 1'b1 && g < LIM) begin @(negedge clk_i); g++; end
    checks++;
    if (tape_o !== 1'b1) begin
      errors++;
      $display("FAIL %s start: tape_o=%b, required 1 within %0d cycles", name, tape_o, LIM);
      return;
    end
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: busy_o=%b, required 1", name, busy_o);
    end
    checks++;
    if (audio_o !== (sound_en_i ? 11'h200 : 11'h000)) begin
      errors++;
      $display("FAIL %s audio: audio_o=%h, required %h", name, audio_o, sound_en_i ? 11'h200 : 11'h000);
    end
    foreach (exp_h[i]) begin
      hi = 0; lo = 0; g = 0;
      while (tape_o === 1'b1 && g < LIM) begin
        if (ce_i && motor_i) hi++;
        @(negedge clk_i); g++;
      end
      while (tape_o === 1'b0 && end_o !== 1'b1 && g < LIM) begin
        if (ce_i && motor_i) lo++;
        @(negedge clk_i); g++;
      end
      checks++;
      if (hi != exp_h[i] || lo != exp_h[i]) begin
        errors++;
        $display("FAIL %s cell %0d: high=%0d low=%0d ticks, required %0d each", name, i, hi, lo, exp_h[i]);
        return;
      end
    end
    checks++;
    if (end_o !== 1'b1 || tape_o !== 1'b0 || busy_o !== 1'b0 || audio_o !== 11'h000) begin
      errors++;
      $display("FAIL %s done: end=%b tape=%b busy=%b audio=%h, required 1 0 0 000",
               name, end_o, tape_o, busy_o, audio_o);
    end
  endtask

  task automatic test_reset();
    step(3);
    @(negedge clk_i);
    checks++; if (tape_o !== 1'b0) begin errors++; $display("FAIL reset tape: got %b, required 0", tape_o); end
    checks++; if (audio_o !== 11'h000) begin errors++; $display("FAIL reset audio: got %h, required 000", audio_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, required 0", busy_o); end
    checks++; if (end_o !== 1'b0) begin errors++; $display("FAIL reset end: got %b, required 0", end_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b, required 0", overflow_o); end
    step(1);
    reset_i = 1'b0;
    step(2);
  endtask

  task automatic load_ref_image();
    rand_img(16);
    img[16] = 8'hA5; img[17] = 8'h00; img[18] = 8'hFF; img[19] = 8'h3C;
    motor_i = 1'b0;
    download(CAS_INDEX, 20);
  endtask

  task automatic test_normal();
    ce_div = 2 + ($urandom % 2);
    fast_i = 1'b1;
    sound_en_i = 1'($urandom);
    load_ref_image();
    @(negedge clk_i);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL normal overflow: got %b, required 0", overflow_o); end
    motor_i = 1'b1;
    play_check("normal");
    motor_i = 1'b0;
  endtask

  task automatic test_fast();
    ce_div = 2 + ($urandom % 2);
    fast_i = 1'b0;
    sound_en_i = 1'($urandom);
    load_ref_image();
    motor_i = 1'b1;
    play_check("fast");
    motor_i = 1'b0;
  endtask

  task automatic pause_motor();
    logic lvl;
    bit   frozen;
    step($urandom_range(1700, 6000));
    motor_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    lvl = tape_o;
    frozen = 1'b1;
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL pause busy: got %b, required 1", busy_o); end
    repeat (300) begin
      @(negedge clk_i);
      if (tape_o !== lvl) frozen = 1'b0;
    end
    checks++;
    if (!frozen) begin errors++; $display("FAIL pause hold: tape_o=%b moved, required held at %b", tape_o, lvl); end
    @(posedge clk_i); #1;
    motor_i = 1'b1;
  endtask

  task automatic test_pause();
    ce_div = 2 + ($urandom % 2);
    fast_i = 1'b1;
    sound_en_i = 1'b1;
    load_ref_image();
    motor_i = 1'b1;
    fork
      play_check("pause");
      pause_motor();
    join
    motor_i = 1'b0;
  endtask

  task automatic test_header_only();
    rand_img(16);
    download(CAS_INDEX, 16);
    motor_i = 1'b1;
    step(300);
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || tape_o !== 1'b0 || end_o !== 1'b0) begin
      errors++;
      $display("FAIL header_only: busy=%b tape=%b end=%b, required 0 0 0", busy_o, tape_o, end_o);
    end
    motor_i = 1'b0;
  endtask

  task automatic test_overflow();
    ce_div = 2;
    fast_i = 1'b0;
    rand_img(40);
    download(CAS_INDEX, 40);
    @(negedge clk_i);
    checks++;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL overflow flag: got %b, required 1", overflow_o); end
    motor_i = 1'b1;
    play_check("overflow");
    motor_i = 1'b0;
  endtask

  task automatic test_abort();
    int g;
    ce_div = 2;
    fast_i = 1'b0;
    rand_img(40);
    download(CAS_INDEX, 40);
    motor_i = 1'b1;
    g = 0;
    while (busy_o !== 1'b1 && g < 1000) begin step(1); g++; end
    step($urandom_range(20, 300));
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL abort pre: busy=%b overflow=%b, required 1 1", busy_o, overflow_o);
    end
    rand_img(20);
    dl_begin(CAS_INDEX);
    @(posedge clk_i); @(negedge clk_i);
    checks++;
    if (tape_o !== 1'b0 || busy_o !== 1'b0 || overflow_o !== 1'b0 || end_o !== 1'b0) begin
      errors++;
      $display("FAIL abort: tape=%b busy=%b overflow=%b end=%b, required 0 0 0 0",
               tape_o, busy_o, overflow_o, end_o);
    end
    for (int a = 0; a < 20; a++) dl_byte(a, img[a]);
    dl_end();
    play_check("after_abort");
    motor_i = 1'b0;
  endtask

  task automatic test_index1_reset();
    int  g, rises;
    logic prev;
    ce_div = 2;
    fast_i = 1'b0;
    sound_en_i = 1'b1;
    rand_img(18);
    download(CAS_INDEX, 18);
    rand_img(24);
    download(1, 24);
    motor_i = 1'b1;
    play_check("index1");
    motor_i = 1'b0;
    rand_img(20);
    dl_begin(CAS_INDEX);
    for (int a = 0; a < 20; a++) dl_byte(a, img[a]);
    dl_byte(100, 8'h55);
    dl_end();
    @(negedge clk_i);
    checks++;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL reset pre overflow: got %b, required 1", overflow_o); end
    motor_i = 1'b1;
    rises = 0; g = 0; prev = tape_o;
    while (rises < LEADER_BITS + 3 && g < LIM) begin
      @(negedge clk_i); g++;
      if (prev === 1'b0 && tape_o === 1'b1) rises++;
      prev = tape_o;
    end
    checks++;
    if (rises < LEADER_BITS + 3) begin
      errors++;
      $display("FAIL reset reach data: rises=%0d, required %0d", rises, LEADER_BITS + 3);
    end
    step(1);
    reset_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (tape_o !== 1'b0 || audio_o !== 11'h000 || busy_o !== 1'b0 || end_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset mid-data: tape=%b audio=%h busy=%b end=%b overflow=%b, required all 0",
               tape_o, audio_o, busy_o, end_o, overflow_o);
    end
    step(2);
    reset_i = 1'b0;
    step(300);
    @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0 || tape_o !== 1'b0) begin
      errors++;
      $display("FAIL reset no replay: busy=%b tape=%b, required 0 0", busy_o, tape_o);
    end
    motor_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    ioctl_download_i = 1'b0;
    ioctl_index_i = 8'd0;
    ioctl_wr_i = 1'b0;
    ioctl_addr_i = '0;
    ioctl_dout_i = 8'd0;
    motor_i = 1'b0;
    fast_i = 1'b1;
    sound_en_i = 1'b1;
    test_reset();
    test_normal();
    test_fast();
    test_pause();
    test_header_only();
    test_overflow();
    test_abort();
    test_index1_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
